// File: rtl/packet_sched_pkg.sv
// Shared FSM encoding and sizing helpers for the packet drain scheduler.
package packet_sched_pkg;

    localparam int pFSM_SCHED_BUS = 3;
    localparam int lpIFG_CYCLES   = 12;
    localparam int lpDRAIN_CYCLES = 2;

    typedef enum logic [pFSM_SCHED_BUS-1:0] {
        lpARB   = 3'd0,
        lpLEN   = 3'd1,
        lpREAD  = 3'd2,
        lpDRAIN = 3'd3,
        lpIFG   = 3'd4
    } sched_state_e;

    // Bits needed to hold a down-counter loaded with values up to max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: the first requester after ptr wins.
module rr_arbiter #(
    parameter int pPORTS = 4
) (
    input  logic [pPORTS-1:0]         req,
    input  logic [$clog2(pPORTS)-1:0] ptr,
    output logic [pPORTS-1:0]         gnt,
    output logic [$clog2(pPORTS)-1:0] idx
);
    localparam int IDX_W = $clog2(pPORTS);
    localparam logic [IDX_W:0] PORTS_W = (IDX_W+1)'(pPORTS);

    logic [IDX_W:0]   pos_sum [pPORTS];
    logic [IDX_W-1:0] pos     [pPORTS];
    logic [pPORTS-1:0] req_rot;

    // req_rot[k] is the requester k+1 places after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < pPORTS; gi++) begin : g_rot
            localparam logic [IDX_W:0] OFF = (IDX_W+1)'(gi + 1);
            assign pos_sum[gi] = {1'b0, ptr} + OFF;
            assign pos[gi]     = (pos_sum[gi] >= PORTS_W) ? IDX_W'(pos_sum[gi] - PORTS_W)
                                                         : pos_sum[gi][IDX_W-1:0];
            assign req_rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        idx = '0;
        gnt = '0;
        for (int i = pPORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                idx = pos[i];
            end
        end
        if (|req_rot) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/packet_drain_scheduler.sv
// Round-robin drain of one whole packet per grant from per-port buffers
// onto a GMII-style byte stream, followed by an inter-frame gap.
module packet_drain_scheduler
    import packet_sched_pkg::*;
#(
    parameter int pPORTS             = 4,
    parameter int pDATA_WIDTH        = 8,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pLEN_W             = $clog2(pMAX_PACKET_LENGHT) + 1,
    parameter int pIFG               = lpIFG_CYCLES
) (
    input  logic                          iclk,
    input  logic                          i_rst,
    input  logic                          ien,
    input  logic [pPORTS-1:0]             imask,
    input  logic [pPORTS-1:0]             iempty,
    input  logic [pPORTS*pLEN_W-1:0]      ilen,
    input  logic [pPORTS*pDATA_WIDTH-1:0] idata,
    output logic [pPORTS-1:0]             ord_en,
    output logic [pDATA_WIDTH-1:0]        otx_d,
    output logic                          otx_en,
    output logic                          otx_sof,
    output logic                          otx_eof,
    output logic [$clog2(pPORTS)-1:0]     ogrant,
    output logic                          obusy,
    output logic                          oerr,
    output logic [15:0]                   opkt_cnt
);
    localparam int IDX_W = $clog2(pPORTS);
    localparam int AUX_W = cnt_width((pIFG > lpDRAIN_CYCLES) ? pIFG : lpDRAIN_CYCLES);
    localparam logic [pLEN_W-1:0] MIN_LEN    = pLEN_W'(pMIN_PACKET_LENGHT);
    localparam logic [pLEN_W-1:0] MAX_LEN    = pLEN_W'(pMAX_PACKET_LENGHT);
    localparam logic [pLEN_W-1:0] ONE_LEN    = pLEN_W'(1);
    localparam logic [AUX_W-1:0]  IFG_LOAD   = AUX_W'(pIFG - 1);
    localparam logic [AUX_W-1:0]  DRAIN_LOAD = AUX_W'(lpDRAIN_CYCLES - 1);

    sched_state_e state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [IDX_W-1:0]  grant_reg, grant_next;
    logic [pLEN_W-1:0] rlen_reg, rlen_next;
    logic [pLEN_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [AUX_W-1:0]  aux_cnt_reg, aux_cnt_next;
    logic              discard_reg, discard_next;

    logic s1_en_reg, s1_en_next;
    logic s1_sof_reg, s1_sof_next;
    logic s1_eof_reg, s1_eof_next;
    logic tx_en_reg, tx_en_next;
    logic tx_sof_reg, tx_sof_next;
    logic tx_eof_reg, tx_eof_next;
    logic [pDATA_WIDTH-1:0] tx_d_reg, tx_d_next;
    logic [15:0] pkt_cnt_reg, pkt_cnt_next;

    logic [pLEN_W-1:0]      len_arr  [pPORTS];
    logic [pDATA_WIDTH-1:0] data_arr [pPORTS];
    logic [pPORTS-1:0]      req_vec;
    logic [pPORTS-1:0]      arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic [pLEN_W-1:0]      head_len;
    logic                   len_illegal;
    logic                   rd_active;

    genvar gi;
    generate
        for (gi = 0; gi < pPORTS; gi++) begin : g_port
            assign len_arr[gi]  = ilen[gi*pLEN_W +: pLEN_W];
            assign data_arr[gi] = idata[gi*pDATA_WIDTH +: pDATA_WIDTH];
            assign ord_en[gi]   = rd_active && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    assign req_vec     = ien ? (~iempty & imask) : '0;
    assign rd_active   = (state_reg == lpREAD);
    assign head_len    = len_arr[grant_reg];
    assign len_illegal = (head_len == '0) || (head_len < MIN_LEN) || (head_len > MAX_LEN);

    rr_arbiter #(
        .pPORTS(pPORTS)
    ) u_rr_arbiter (
        .req(req_vec),
        .ptr(ptr_reg),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        grant_next    = grant_reg;
        rlen_next     = rlen_reg;
        byte_cnt_next = byte_cnt_reg;
        aux_cnt_next  = aux_cnt_reg;
        discard_next  = discard_reg;
        case (state_reg)
            lpARB: begin
                if (|arb_gnt) begin
                    ptr_next   = arb_idx;
                    grant_next = arb_idx;
                    state_next = lpLEN;
                end
            end
            lpLEN: begin
                rlen_next     = head_len;
                byte_cnt_next = head_len;
                discard_next  = len_illegal;
                if (head_len == '0) begin
                    aux_cnt_next = IFG_LOAD;
                    state_next   = lpIFG;
                end else begin
                    state_next   = lpREAD;
                end
            end
            lpREAD: begin
                byte_cnt_next = byte_cnt_reg - ONE_LEN;
                if (byte_cnt_reg == ONE_LEN) begin
                    aux_cnt_next = DRAIN_LOAD;
                    state_next   = lpDRAIN;
                end
            end
            lpDRAIN: begin
                if (aux_cnt_reg == '0) begin
                    aux_cnt_next = IFG_LOAD;
                    state_next   = lpIFG;
                end else begin
                    aux_cnt_next = aux_cnt_reg - 1'b1;
                end
            end
            lpIFG: begin
                if (aux_cnt_reg == '0) begin
                    state_next = lpARB;
                end else begin
                    aux_cnt_next = aux_cnt_reg - 1'b1;
                end
            end
            default: state_next = lpARB;
        endcase
    end

    // Stage 1 tracks the read request; stage 2 meets the buffer's 1-cycle read data.
    always_comb begin
        s1_en_next   = rd_active && !discard_reg;
        s1_sof_next  = rd_active && (byte_cnt_reg == rlen_reg);
        s1_eof_next  = rd_active && (byte_cnt_reg == ONE_LEN);
        tx_en_next   = s1_en_reg;
        tx_sof_next  = s1_en_reg && s1_sof_reg;
        tx_eof_next  = s1_en_reg && s1_eof_reg;
        tx_d_next    = s1_en_reg ? data_arr[grant_reg] : tx_d_reg;
        pkt_cnt_next = pkt_cnt_reg + 16'(s1_en_reg && s1_eof_reg);
    end

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= lpARB;
            ptr_reg      <= IDX_W'(pPORTS - 1);
            grant_reg    <= '0;
            rlen_reg     <= '0;
            byte_cnt_reg <= '0;
            aux_cnt_reg  <= '0;
            discard_reg  <= 1'b0;
            s1_en_reg    <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_eof_reg   <= 1'b0;
            tx_en_reg    <= 1'b0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
            tx_d_reg     <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            grant_reg    <= grant_next;
            rlen_reg     <= rlen_next;
            byte_cnt_reg <= byte_cnt_next;
            aux_cnt_reg  <= aux_cnt_next;
            discard_reg  <= discard_next;
            s1_en_reg    <= s1_en_next;
            s1_sof_reg   <= s1_sof_next;
            s1_eof_reg   <= s1_eof_next;
            tx_en_reg    <= tx_en_next;
            tx_sof_reg   <= tx_sof_next;
            tx_eof_reg   <= tx_eof_next;
            tx_d_reg     <= tx_d_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    assign otx_d    = tx_d_reg;
    assign otx_en   = tx_en_reg;
    assign otx_sof  = tx_sof_reg;
    assign otx_eof  = tx_eof_reg;
    assign ogrant   = grant_reg;
    assign obusy    = (state_reg != lpARB);
    assign oerr     = (state_reg == lpLEN) && len_illegal;
    assign opkt_cnt = pkt_cnt_reg;

endmodule

// File: tb/tb_packet_drain_scheduler.sv
// Scoreboard bench: per-port buffer models feed the scheduler, expected packets are queued in grant order.
module tb_packet_drain_scheduler;
    localparam int P   = 4;
    localparam int DW  = 8;
    localparam int LW  = 12;
    localparam int IFG = 12;

    typedef struct {
        int port;
        int len;
        int id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [P-1:0] mask = '0;
    logic [P-1:0] empty;
    logic [P*LW-1:0] len_bus;
    logic [P*DW-1:0] data_bus;
    logic [P-1:0] ord_en;
    logic [DW-1:0] tx_d;
    logic tx_en, tx_sof, tx_eof, obusy, oerr;
    logic [1:0] ogrant;
    logic [15:0] opkt_cnt;

    int total = 0;
    int bad = 0;

    // buffer model state
    int buf_len [P][8];
    int buf_id  [P][8];
    int head   [P] = '{default: 0};
    int tail   [P] = '{default: 0};
    int rd_idx [P] = '{default: 0};
    logic [DW-1:0] idata_arr [P];
    int next_id = 1;

    // monitor state
    exp_t exp_q[$];
    exp_t cur;
    int cyc = 0;
    int ord_start = 0;
    int last_eof_cyc = 0;
    int last_eof_epoch = 0;
    int gap_epoch = 0;
    int byte_i = 0;
    int bad_bytes = 0;
    int onehot_bad = 0;
    int stray = 0;
    int err_cnt = 0;
    int ord_cnt [P] = '{default: 0};
    bit in_pkt = 1'b0;
    bit has_cur = 1'b0;
    logic [P-1:0] prev_ord = '0;

    // snapshots
    int snap_ord;
    int snap_err;
    int id_tmp;
    int id_late;

    packet_drain_scheduler dut (
        .iclk(clk),
        .i_rst(rst_n),
        .ien(en),
        .imask(mask),
        .iempty(empty),
        .ilen(len_bus),
        .idata(data_bus),
        .ord_en(ord_en),
        .otx_d(tx_d),
        .otx_en(tx_en),
        .otx_sof(tx_sof),
        .otx_eof(tx_eof),
        .ogrant(ogrant),
        .obusy(obusy),
        .oerr(oerr),
        .opkt_cnt(opkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pkt_byte(input int id, input int i);
        int v;
        v = id * 29 + i * 7 + 3;
        return v[7:0];
    endfunction

    function automatic void check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    always_comb begin
        empty    = '0;
        len_bus  = '0;
        data_bus = '0;
        for (int p = 0; p < P; p++) begin
            empty[p]              = (head[p] == tail[p]);
            len_bus[p*LW +: LW]   = LW'(buf_len[p][head[p] % 8]);
            data_bus[p*DW +: DW]  = idata_arr[p];
        end
    end

    // Buffers return one byte per read enable; a reset flushes a partially read head packet.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < P; p++) begin
                if (rd_idx[p] != 0) begin
                    head[p]   <= head[p] + 1;
                    rd_idx[p] <= 0;
                end
            end
        end else begin
            for (int p = 0; p < P; p++) begin
                if (ord_en[p]) begin
                    idata_arr[p] <= pkt_byte(buf_id[p][head[p] % 8], rd_idx[p]);
                    if (rd_idx[p] + 1 >= buf_len[p][head[p] % 8]) begin
                        head[p]   <= head[p] + 1;
                        rd_idx[p] <= 0;
                    end else begin
                        rd_idx[p] <= rd_idx[p] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_pkt   = 1'b0;
            has_cur  = 1'b0;
            prev_ord = '0;
        end else begin
            if ($countones(ord_en) > 1) onehot_bad++;
            for (int p = 0; p < P; p++) ord_cnt[p] += int'(ord_en[p]);
            if (ord_en != '0 && prev_ord == '0) ord_start = cyc;
            prev_ord = ord_en;
            if (oerr) err_cnt++;
            if (tx_en) begin
                if (tx_sof) begin
                    check("sof_inside_packet", in_pkt, 0);
                    in_pkt    = 1'b1;
                    byte_i    = 0;
                    bad_bytes = 0;
                    if (exp_q.size() == 0) begin
                        has_cur = 1'b0;
                        check("pending_expected", exp_q.size(), 1);
                    end else begin
                        cur     = exp_q.pop_front();
                        has_cur = 1'b1;
                        check("grant_port", ogrant, cur.port);
                        check("sof_latency", cyc - ord_start, 2);
                        if (gap_epoch != 0 && last_eof_epoch == gap_epoch)
                            check("ifg_idle_cycles", cyc - last_eof_cyc - 1, IFG + 4);
                    end
                end else if (!in_pkt) begin
                    stray++;
                end
                if (has_cur && tx_d != pkt_byte(cur.id, byte_i)) bad_bytes++;
                byte_i++;
                if (tx_eof) begin
                    if (has_cur) begin
                        $display("pkt port=%0d id=%0d bytes=%0d data_errs=%0d cnt=%0d",
                                 cur.port, cur.id, byte_i, bad_bytes, opkt_cnt);
                        check("pkt_len", byte_i, cur.len);
                        check("pkt_data_errs", bad_bytes, 0);
                    end
                    in_pkt         = 1'b0;
                    has_cur        = 1'b0;
                    last_eof_cyc   = cyc;
                    last_eof_epoch = gap_epoch;
                end
            end
        end
    end

    task automatic send(input int port, input int len, input bit want_out, output int id);
        id = next_id;
        next_id++;
        buf_len[port][tail[port] % 8] = len;
        buf_id[port][tail[port] % 8]  = id;
        tail[port] = tail[port] + 1;
        if (want_out) exp_q.push_back('{port: port, len: len, id: id});
    endtask

    task automatic wait_idle(input logic [P-1:0] drain, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !in_pkt && !obusy && ((~empty & drain) == '0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", n < budget, 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_ord(input int port, input int budget);
        int n;
        n = 0;
        while (!ord_en[port] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ord_start_within_budget", n < budget, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ord_en", ord_en, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_busy", obusy, 0);
        check("rst_pkt_cnt", opkt_cnt, 0);
        check("rst_grant", ogrant, 0);
        check("rst_err", oerr, 0);
        #1 rst_n = 1'b1;
        en   = 1'b1;
        mask = '1;

        // single 64-byte packet on port 0
        @(negedge clk); #1;
        snap_ord = ord_cnt[0];
        send(0, 64, 1'b1, id_tmp);
        wait_idle('1, 3000);
        check("t1_ord_cycles", ord_cnt[0] - snap_ord, 64);
        check("t1_pkt_cnt", opkt_cnt, 1);

        // back-to-back on ports 1 and 2: order 1,2,1,2 with fixed gap
        @(negedge clk); #1;
        gap_epoch = 2;
        send(1, 64, 1'b1, id_tmp);
        send(2, 64, 1'b1, id_tmp);
        send(1, 64, 1'b1, id_tmp);
        send(2, 64, 1'b1, id_tmp);
        wait_idle('1, 4000);
        gap_epoch = 0;
        check("t2_pkt_cnt", opkt_cnt, 5);

        // illegal lengths on port 3 are read out but not emitted
        @(negedge clk); #1;
        snap_ord = ord_cnt[3];
        snap_err = err_cnt;
        send(3, 10, 1'b0, id_tmp);
        send(3, 63, 1'b0, id_tmp);
        send(3, 64, 1'b1, id_tmp);
        wait_idle('1, 3000);
        check("t3_err_pulses", err_cnt - snap_err, 2);
        check("t3_ord_cycles", ord_cnt[3] - snap_ord, 10 + 63 + 64);
        check("t3_pkt_cnt", opkt_cnt, 6);

        // ien dropped mid-packet: packet finishes, no new grant until re-enabled
        @(negedge clk); #1;
        snap_ord = ord_cnt[0];
        send(0, 64, 1'b1, id_tmp);
        send(0, 64, 1'b0, id_late);
        wait_ord(0, 100);
        repeat (10) @(negedge clk);
        #1 en = 1'b0;
        wait_idle('0, 3000);
        check("t4_ord_cycles_parked", ord_cnt[0] - snap_ord, 64);
        check("t4_parked_busy", obusy, 0);
        check("t4_pkt_cnt", opkt_cnt, 7);
        #1 en = 1'b1;
        exp_q.push_back('{port: 0, len: 64, id: id_late});
        wait_idle('1, 3000);
        check("t4_ord_cycles_total", ord_cnt[0] - snap_ord, 128);
        check("t4_pkt_cnt_after", opkt_cnt, 8);

        // async reset in the middle of a 100-byte packet
        apply_reset();
        check("t5_cnt_cleared", opkt_cnt, 0);
        @(negedge clk); #1;
        send(0, 100, 1'b1, id_tmp);
        send(0, 64, 1'b1, id_tmp);
        send(1, 64, 1'b1, id_tmp);
        wait_ord(0, 100);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ord_en", ord_en, 0);
        check("t5_rst_tx_en", tx_en, 0);
        check("t5_rst_busy", obusy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_idle('1, 3000);
        check("t5_pkt_cnt", opkt_cnt, 2);

        // port 2 masked: order 0,1,3,0 and port 2 stays untouched
        apply_reset();
        @(negedge clk); #1;
        mask = 4'b1011;
        snap_ord = ord_cnt[2];
        send(0, 64, 1'b1, id_tmp);
        send(1, 64, 1'b1, id_tmp);
        send(3, 64, 1'b1, id_tmp);
        send(0, 64, 1'b1, id_tmp);
        send(2, 64, 1'b0, id_late);
        wait_idle(4'b1011, 4000);
        check("t6_port2_reads", ord_cnt[2] - snap_ord, 0);
        check("t6_pkt_cnt", opkt_cnt, 4);
        #1 mask = '1;
        exp_q.push_back('{port: 2, len: 64, id: id_late});
        wait_idle('1, 3000);
        check("t6_port2_reads_after", ord_cnt[2] - snap_ord, 64);
        check("t6_pkt_cnt_after", opkt_cnt, 5);

        check("ord_onehot_violations", onehot_bad, 0);
        check("stray_bytes", stray, 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_drain_scheduler.md
Name: packet_drain_scheduler

Overview:
- Round-robin read scheduler for pPORTS packet buffers, one per RX port. Each buffer exposes its empty flag, head-of-queue packet length, a read enable and byte data with a 1-cycle read latency.
- Picks the next non-empty buffer and drains exactly one whole packet from it.
- Emits the packet as a GMII-style TX byte stream, then enforces an inter-frame gap before the next grant.
- Sits between the per-port packet memories and the TX MAC/forwarding stage.

Parameters:
pPORTS, 4, number of packet buffers arbitrated (2..8)
pDATA_WIDTH, 8, byte width of buffer and TX data
pMIN_PACKET_LENGHT, 64, smallest legal packet length in bytes
pMAX_PACKET_LENGHT, 1536, largest legal packet length in bytes
pLEN_W, $clog2(pMAX_PACKET_LENGHT)+1, width of the length fields
pIFG, 12, inter-frame gap cycles (>=1)

Ports:
iclk  in  1  clock
i_rst  in  1  asynchronous reset, active-low
ien  in  1  scheduler enable; low = no new grants
imask  in  pPORTS  per-port grant enable
iempty  in  pPORTS  buffer empty flags
ilen  in  pPORTS*pLEN_W  head packet length per port, valid while !iempty
idata  in  pPORTS*pDATA_WIDTH  buffer read data, 1 cycle after ord_en
ord_en  out  pPORTS  one-hot buffer read enable
otx_d  out  pDATA_WIDTH  TX byte
otx_en  out  1  TX byte valid
otx_sof  out  1  first byte of packet
otx_eof  out  1  last byte of packet
ogrant  out  $clog2(pPORTS)  currently/last granted port
obusy  out  1  state != ARB
oerr  out  1  1-cycle pulse: illegal length
opkt_cnt  out  16  good packets sent, wraps

Behaviour:
- Reset (i_rst low, async): all outputs 0, FSM=ARB, RR pointer=pPORTS-1 (so port 0 wins first), counters 0. ord_en drops immediately. A packet in flight is abandoned with no eof.
- FSM states: ARB, LEN, READ, DRAIN, IFG.
- ARB:
  - Candidates = !iempty & imask, considered only when ien=1.
  - Search order starts at pointer+1 mod pPORTS; first candidate wins, pointer <= winner, ogrant <= winner, go to LEN.
  - No candidate: stay in ARB.
- LEN (1 cycle):
  - Capture ilen[winner] into rlen; byte counter <= rlen.
  - rlen < pMIN_PACKET_LENGHT or > pMAX_PACKET_LENGHT: set discard flag, pulse oerr.
  - rlen==0: treat as illegal, skip READ, go to IFG.
- READ:
  - ord_en[winner]=1 for exactly rlen consecutive cycles; counter decrements each cycle.
  - Leave to DRAIN on the cycle the counter reaches 1.
- Output pipeline:
  - A 2-stage pipeline of {en, sof, eof}; stage 2 also registers idata[winner].
  - otx_en is asserted 2 cycles after the matching ord_en cycle.
  - otx_sof on byte 0, otx_eof on byte rlen-1; for rlen=1 both are set on the same cycle.
- Discard: bytes are still read, with ord_en asserted for rlen cycles so the buffer advances, but otx_en/sof/eof stay 0 and opkt_cnt does not increment.
- DRAIN: 2 cycles, flushing the pipeline.
- opkt_cnt: +1 on the cycle otx_eof=1 is emitted.
- IFG: count pIFG cycles, then ARB.
- Back-to-back timing: the last otx_en of packet N and the first otx_en of packet N+1 are separated by exactly pIFG+4 idle cycles.
- ien or imask falling mid-packet: the current packet completes fully; this only blocks the next ARB decision.
- iempty/ilen changes after the LEN cycle are ignored.
- Only one ord_en bit is ever high. otx_d holds its last value when otx_en=0.

Decomposition:
- Package packet_sched_pkg: state encoding (lpARB, lpLEN, lpREAD, lpDRAIN, lpIFG), pFSM_SCHED_BUS width, default lpIFG_CYCLES.
- Sub-module rr_arbiter: combinational rotate-priority pick from the request vector and pointer. Outputs a one-hot grant and an index. Pointer register stays in the parent.

Test Plan:
- Port 0 non-empty, ilen=64, others empty -> ord_en[0] high 64 cycles; otx_en 64 cycles starting 2 cycles after first ord_en; sof on byte 0, eof on byte 63; opkt_cnt=1.
- Ports 1 and 2 each hold two 64-byte packets, ien=1 -> grant order 1,2,1,2; exactly 16 idle otx_en cycles between packets; opkt_cnt=4.
- imask=4'b1011, all ports non-empty -> port 2 never granted; order 0,1,3,0.
- Port 3 ilen=10 -> oerr pulse in LEN; ord_en[3] high 10 cycles; otx_en never asserted; opkt_cnt unchanged.
- i_rst low at byte 30 of a 100-byte packet -> ord_en, otx_en, obusy 0 without a clock edge; after release, port 0 is granted first.
- ien dropped at byte 10 of 64 -> all 64 bytes emitted with eof; FSM parks in ARB after IFG; no new ord_en until ien=1.
